// File: rtl/eth_rx_checker.sv
// XGMII 64-bit receive checker. It finds frame boundaries, strips the preamble/SFD,
// streams the payload out as valid/last beats, and keeps frame, byte, error and gap statistics.

module eth_rx_lane_dec (
    input  logic       i_ctrl,
    input  logic [7:0] i_byte,
    output logic       o_idle,
    output logic       o_start,
    output logic       o_term
);
    assign o_idle  = i_ctrl && (i_byte == 8'h07);
    assign o_start = i_ctrl && (i_byte == 8'hFB);
    assign o_term  = i_ctrl && (i_byte == 8'hFD);
endmodule

module eth_rx_checker #(
    parameter int min_ifg   = 12,
    parameter int cnt_width = 32
) (
    input  logic                 user_clk,
    input  logic                 cold_reset_n,
    input  logic [63:0]          xgmii_rxd,
    input  logic [7:0]           xgmii_rxc,
    input  logic                 stat_clr,
    output logic [63:0]          m_tdata,
    output logic [7:0]           m_tkeep,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    output logic                 m_tuser,
    output logic [cnt_width-1:0] frame_cnt,
    output logic [47:0]          byte_cnt,
    output logic [15:0]          err_cnt,
    output logic [15:0]          ifg_viol_cnt,
    output logic [15:0]          ifg_last
);
    localparam int          NUM_LANES  = 8;
    localparam logic [63:0] START_WORD = 64'hD5555555555555FB;

    typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;

    typedef struct packed {
        logic        vld;
        logic        last;
        logic        user;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

    typedef struct packed {
        logic        vld;
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } hold_t;

    function automatic logic [15:0] f_gap_add(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    state_t               r_st, w_st_nxt;
    hold_t                r_hold, w_hold_nxt;
    logic [31:0]          r_len, w_len_nxt;
    logic [15:0]          r_gap, w_gap_nxt;
    beat_t                w_beat, w_hold_beat, w_bad_beat;
    logic                 w_good, w_open, w_term, w_new_fb, w_legal, w_tail_idle;
    logic [1:0]           w_err;
    logic [15:0]          w_open_gap;
    logic [NUM_LANES-1:0] w_idle, w_fb, w_fd;
    logic [2:0]           w_k, w_fb_lane, w_fd_lane;
    logic [3:0]           w_idle_all, w_idle_pre;
    logic [7:0]           w_keep_k;
    logic [63:0]          w_data_k;
    logic [48:0]          w_byte_sum;
    logic [16:0]          w_err_sum;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        eth_rx_lane_dec u_dec (
            .i_ctrl  (xgmii_rxc[g]),
            .i_byte  (xgmii_rxd[8*g +: 8]),
            .o_idle  (w_idle[g]),
            .o_start (w_fb[g]),
            .o_term  (w_fd[g])
        );
    end

    // Lowest control / start / terminate lane, and idle-lane counts for gap measurement.
    always_comb begin
        w_k         = '0;
        w_fb_lane   = '0;
        w_fd_lane   = '0;
        w_tail_idle = 1'b1;
        w_idle_all  = '0;
        w_idle_pre  = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (xgmii_rxc[i]) w_k = 3'(i);
            if (w_fb[i])      w_fb_lane = 3'(i);
            if (w_fd[i])      w_fd_lane = 3'(i);
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            if (i > int'(w_k) && !w_idle[i]) w_tail_idle = 1'b0;
            if (w_idle[i]) begin
                w_idle_all = w_idle_all + 4'd1;
                if (i < int'(w_fb_lane)) w_idle_pre = w_idle_pre + 4'd1;
            end
        end
        w_keep_k = 8'((9'd1 << w_k) - 9'd1);
        for (int i = 0; i < NUM_LANES; i++)
            w_data_k[8*i +: 8] = w_keep_k[i] ? xgmii_rxd[8*i +: 8] : 8'h00;
    end

    assign w_term   = (|xgmii_rxc) && w_fd[w_k] && w_tail_idle;
    assign w_new_fb = (|xgmii_rxc) && w_fb[w_k];
    assign w_legal  = (xgmii_rxc == 8'h01) && (xgmii_rxd == START_WORD);

    assign w_hold_beat = '{vld: r_hold.vld, last: 1'b0, user: 1'b0,
                           keep: r_hold.keep, data: r_hold.data};
    assign w_bad_beat  = '{vld: 1'b1, last: 1'b1, user: 1'b1,
                           keep: r_hold.vld ? r_hold.keep : 8'h00,
                           data: r_hold.vld ? r_hold.data : 64'd0};

    always_comb begin
        w_st_nxt   = r_st;
        w_hold_nxt = r_hold;
        w_beat     = '0;
        w_len_nxt  = r_len;
        w_gap_nxt  = r_gap;
        w_good     = 1'b0;
        w_err      = 2'd0;
        w_open     = 1'b0;
        w_open_gap = 16'd0;

        // A held partial last beat goes out on the next cycle whatever arrives.
        if (r_hold.vld && r_hold.last) begin
            w_beat     = '{vld: 1'b1, last: 1'b1, user: 1'b0, keep: r_hold.keep, data: r_hold.data};
            w_good     = 1'b1;
            w_hold_nxt = '0;
        end

        case (r_st)
            IDLE: begin
                if (|w_fb) begin
                    w_open     = 1'b1;
                    w_open_gap = f_gap_add(r_gap, w_idle_pre);
                end else begin
                    w_gap_nxt  = f_gap_add(r_gap, w_idle_all);
                end
            end
            DATA: begin
                if (xgmii_rxc == 8'h00) begin
                    w_beat     = w_hold_beat;
                    w_hold_nxt = '{vld: 1'b1, last: 1'b0, keep: 8'hFF, data: xgmii_rxd};
                    w_len_nxt  = r_len + 32'd8;
                end else if (w_term) begin
                    w_st_nxt  = IDLE;
                    w_gap_nxt = 16'd8 - {13'd0, w_k};
                    if (w_k != 3'd0) begin
                        w_beat     = w_hold_beat;
                        w_hold_nxt = '{vld: 1'b1, last: 1'b1, keep: w_keep_k, data: w_data_k};
                        w_len_nxt  = r_len + {29'd0, w_k};
                    end else if (r_hold.vld) begin
                        w_beat      = w_hold_beat;
                        w_beat.last = 1'b1;
                        w_good      = 1'b1;
                        w_hold_nxt  = '0;
                    end else begin
                        w_beat = w_bad_beat;
                        w_err  = 2'd1;
                    end
                end else begin
                    w_beat     = w_bad_beat;
                    w_err      = 2'd1;
                    w_hold_nxt = '0;
                    if (w_new_fb) w_open   = 1'b1;
                    else          w_st_nxt = DROP;
                end
            end
            DROP: begin
                if (|w_fd) begin
                    w_st_nxt  = IDLE;
                    w_gap_nxt = 16'd8 - {13'd0, w_fd_lane};
                end
            end
            default: w_st_nxt = IDLE;
        endcase

        if (w_open) begin
            w_gap_nxt = '0;
            w_len_nxt = '0;
            if (w_legal) begin
                w_st_nxt = DATA;
            end else begin
                w_st_nxt = DROP;
                w_err    = w_err + 2'd1;
            end
        end
    end

    assign w_byte_sum = {1'b0, byte_cnt} + {17'd0, r_len};
    assign w_err_sum  = {1'b0, err_cnt} + {15'd0, w_err};

    always_ff @(posedge user_clk or negedge cold_reset_n) begin
        if (!cold_reset_n) begin
            r_st         <= IDLE;
            r_hold       <= '0;
            r_len        <= '0;
            r_gap        <= 16'hFFFF;
            m_tdata      <= '0;
            m_tkeep      <= '0;
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
            m_tuser      <= 1'b0;
            frame_cnt    <= '0;
            byte_cnt     <= '0;
            err_cnt      <= '0;
            ifg_viol_cnt <= '0;
            ifg_last     <= '0;
        end else begin
            r_st     <= w_st_nxt;
            r_hold   <= w_hold_nxt;
            r_len    <= w_len_nxt;
            r_gap    <= w_gap_nxt;
            m_tdata  <= w_beat.data;
            m_tkeep  <= w_beat.keep;
            m_tvalid <= w_beat.vld;
            m_tlast  <= w_beat.last;
            m_tuser  <= w_beat.user;
            if (stat_clr) begin
                frame_cnt    <= '0;
                byte_cnt     <= '0;
                err_cnt      <= '0;
                ifg_viol_cnt <= '0;
                ifg_last     <= '0;
            end else begin
                if (w_good) begin
                    if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
                    byte_cnt <= w_byte_sum[48] ? '1 : w_byte_sum[47:0];
                end
                err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
                if (w_open) begin
                    ifg_last <= w_open_gap;
                    if (w_open_gap < 16'(min_ifg) && ifg_viol_cnt != 16'hFFFF)
                        ifg_viol_cnt <= ifg_viol_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_eth_rx_checker.sv
// Directed bench for eth_rx_checker: framing, partial last beats, gap accounting,
// error frames, start-in-lane-4 drop, mid-frame reset and counter clear.

module tb_eth_rx_checker;
    localparam logic [63:0] IDLE_W  = {8{8'h07}};
    localparam logic [63:0] START_W = 64'hD5555555555555FB;

    logic        user_clk = 1'b0;
    logic        cold_reset_n;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic        stat_clr;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tlast, m_tuser;
    logic [31:0] frame_cnt;
    logic [47:0] byte_cnt;
    logic [15:0] err_cnt, ifg_viol_cnt, ifg_last;
    logic [63:0] fe_w;

    int checks = 0;
    int errors = 0;

    eth_rx_checker #(.min_ifg(12), .cnt_width(32)) dut (
        .user_clk(user_clk), .cold_reset_n(cold_reset_n),
        .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc), .stat_clr(stat_clr),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .m_tuser(m_tuser),
        .frame_cnt(frame_cnt), .byte_cnt(byte_cnt), .err_cnt(err_cnt),
        .ifg_viol_cnt(ifg_viol_cnt), .ifg_last(ifg_last)
    );

    always #5 user_clk = ~user_clk;

    function automatic logic [63:0] dw(input int i);
        logic [7:0] b;
        b = 8'(i << 4);
        return 64'h0706050403020100 | {8{b}};
    endfunction

    // Terminate word: lanes below k carry d, lane k is FD, the rest idle.
    function automatic logic [63:0] tw(input int k, input logic [63:0] d);
        logic [63:0] r;
        for (int l = 0; l < 8; l++)
            r[8*l +: 8] = (l < k) ? d[8*l +: 8] : ((l == k) ? 8'hFD : 8'h07);
        return r;
    endfunction

    function automatic logic [7:0] tc(input int k);
        logic [7:0] ones;
        ones = 8'hFF;
        return 8'(ones << k);
    endfunction

    function automatic logic [63:0] kmask(input logic [7:0] keep);
        logic [63:0] m;
        for (int l = 0; l < 8; l++) m[8*l +: 8] = {8{keep[l]}};
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] c);
        xgmii_rxd = d;
        xgmii_rxc = c;
        @(posedge user_clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic l, input logic u,
                        input logic [7:0] keep, input logic [63:0] d);
        chk({tag, ".valid"}, 64'(m_tvalid), 64'd1);
        chk({tag, ".last"},  64'(m_tlast),  64'(l));
        chk({tag, ".user"},  64'(m_tuser),  64'(u));
        chk({tag, ".keep"},  64'(m_tkeep),  64'(keep));
        chk({tag, ".data"},  m_tdata & kmask(keep), d & kmask(keep));
    endtask

    task automatic nobeat(input string tag);
        chk({tag, ".valid"}, 64'(m_tvalid), 64'd0);
    endtask

    task automatic cnts(input string tag, input int f, input int b, input int e,
                        input int v, input int g);
        chk({tag, ".frame_cnt"}, 64'(frame_cnt),    64'(f));
        chk({tag, ".byte_cnt"},  64'(byte_cnt),     64'(b));
        chk({tag, ".err_cnt"},   64'(err_cnt),      64'(e));
        chk({tag, ".ifg_viol"},  64'(ifg_viol_cnt), 64'(v));
        chk({tag, ".ifg_last"},  64'(ifg_last),     64'(g));
    endtask

    // Drives n payload words; beat i-1 must appear as word i is consumed.
    task automatic data_words(input string tag, input int n);
        for (int i = 1; i <= n; i++) begin
            drive(dw(i), 8'h00);
            if (i == 1) nobeat({tag, ".lat"});
            else        beat($sformatf("%s.b%0d", tag, i - 1), 1'b0, 1'b0, 8'hFF, dw(i - 1));
        end
    endtask

    initial begin
        xgmii_rxd    = IDLE_W;
        xgmii_rxc    = 8'hFF;
        stat_clr     = 1'b0;
        cold_reset_n = 1'b0;
        repeat (3) @(posedge user_clk);
        #1;
        nobeat("rst");
        chk("rst.tdata", m_tdata, 64'd0);
        chk("rst.tkeep", 64'(m_tkeep), 64'd0);
        chk("rst.tlast", 64'(m_tlast), 64'd0);
        chk("rst.tuser", 64'(m_tuser), 64'd0);
        cnts("rst", 0, 0, 0, 0, 0);
        cold_reset_n = 1'b1;
        drive(IDLE_W, 8'hFF);
        drive(IDLE_W, 8'hFF);

        // 64-byte frame, FD in lane 0
        drive(START_W, 8'h01);
        nobeat("f1.start");
        data_words("f1", 8);
        drive(tw(0, 64'd0), tc(0));
        beat("f1.last", 1'b1, 1'b0, 8'hFF, dw(8));
        cnts("f1", 1, 64, 0, 0, 16'hFFFF);

        // 65-byte frame, FD in lane 1
        drive(IDLE_W, 8'hFF);
        drive(START_W, 8'h01);
        chk("f2.ifg", 64'(ifg_last), 64'd16);
        data_words("f2", 8);
        drive(tw(1, dw(9)), tc(1));
        beat("f2.b8", 1'b0, 1'b0, 8'hFF, dw(8));
        drive(IDLE_W, 8'hFF);
        beat("f2.last", 1'b1, 1'b0, 8'h01, dw(9));
        cnts("f2", 2, 129, 0, 0, 16);

        // 20-byte frame, FD in lane 4, followed by one idle word: gap 12
        drive(START_W, 8'h01);
        chk("f3.ifg", 64'(ifg_last), 64'd15);
        data_words("f3", 2);
        drive(tw(4, dw(3)), tc(4));
        beat("f3.b2", 1'b0, 1'b0, 8'hFF, dw(2));
        drive(IDLE_W, 8'hFF);
        beat("f3.last", 1'b1, 1'b0, 8'h0F, dw(3));
        cnts("f3", 3, 149, 0, 0, 15);

        drive(START_W, 8'h01);
        chk("f4.ifg", 64'(ifg_last), 64'd12);
        chk("f4.viol", 64'(ifg_viol_cnt), 64'd0);
        data_words("f4", 1);
        drive(tw(0, 64'd0), tc(0));
        beat("f4.last", 1'b1, 1'b0, 8'hFF, dw(1));
        cnts("f4", 4, 157, 0, 0, 12);

        // Back-to-back start: gap 8 is a violation; FE in lane 3 of word 4
        drive(START_W, 8'h01);
        chk("f5.ifg", 64'(ifg_last), 64'd8);
        chk("f5.viol", 64'(ifg_viol_cnt), 64'd1);
        data_words("f5", 3);
        fe_w = dw(4);
        fe_w[31:24] = 8'hFE;
        drive(fe_w, 8'h08);
        beat("f5.bad", 1'b1, 1'b1, 8'hFF, dw(3));
        cnts("f5", 4, 157, 1, 1, 8);
        drive(tw(0, 64'd0), tc(0));
        nobeat("f5.drop_fd");
        drive(IDLE_W, 8'hFF);
        nobeat("f5.idle");

        drive(START_W, 8'h01);
        chk("f6.ifg", 64'(ifg_last), 64'd16);
        data_words("f6", 1);
        drive(tw(2, dw(2)), tc(2));
        beat("f6.b1", 1'b0, 1'b0, 8'hFF, dw(1));
        drive(IDLE_W, 8'hFF);
        beat("f6.last", 1'b1, 1'b0, 8'h03, dw(2));
        cnts("f6", 5, 167, 1, 1, 16);

        // Start in lane 4: whole frame dropped, counted once as an error
        drive(64'h555555FB07070707, 8'h1F);
        nobeat("l4.start");
        chk("l4.ifg", 64'(ifg_last), 64'd18);
        chk("l4.err", 64'(err_cnt), 64'd2);
        drive(dw(1), 8'h00);
        nobeat("l4.d1");
        drive(dw(2), 8'h00);
        nobeat("l4.d2");
        drive(tw(0, 64'd0), tc(0));
        nobeat("l4.fd");
        drive(IDLE_W, 8'hFF);
        nobeat("l4.idle");

        drive(START_W, 8'h01);
        chk("f7.ifg", 64'(ifg_last), 64'd16);
        data_words("f7", 2);
        drive(tw(0, 64'd0), tc(0));
        beat("f7.last", 1'b1, 1'b0, 8'hFF, dw(2));
        cnts("f7", 6, 183, 2, 1, 16);
        drive(IDLE_W, 8'hFF);

        // New start while in a frame: old frame closed bad, new one kept with gap 0
        drive(START_W, 8'h01);
        data_words("f8a", 1);
        drive(START_W, 8'h01);
        beat("f8a.bad", 1'b1, 1'b1, 8'hFF, dw(1));
        cnts("f8a", 6, 183, 3, 2, 0);
        data_words("f8b", 1);
        drive(tw(0, 64'd0), tc(0));
        beat("f8b.last", 1'b1, 1'b0, 8'hFF, dw(1));
        cnts("f8b", 7, 191, 3, 2, 0);

        // Reset in the middle of a frame
        drive(IDLE_W, 8'hFF);
        drive(START_W, 8'h01);
        data_words("f9", 2);
        cold_reset_n = 1'b0;
        xgmii_rxd    = IDLE_W;
        xgmii_rxc    = 8'hFF;
        #1;
        nobeat("mrst");
        chk("mrst.tdata", m_tdata, 64'd0);
        cnts("mrst", 0, 0, 0, 0, 0);
        @(posedge user_clk);
        #1;
        cold_reset_n = 1'b1;
        drive(IDLE_W, 8'hFF);
        nobeat("mrst.idle");
        drive(START_W, 8'h01);
        chk("f10.ifg", 64'(ifg_last), 64'hFFFF);
        chk("f10.viol", 64'(ifg_viol_cnt), 64'd0);
        data_words("f10", 2);
        stat_clr = 1'b1;
        drive(tw(0, 64'd0), tc(0));
        stat_clr = 1'b0;
        beat("f10.last", 1'b1, 1'b0, 8'hFF, dw(2));
        cnts("clr", 0, 0, 0, 0, 0);
        drive(IDLE_W, 8'hFF);
        nobeat("clr.idle");
        cnts("clr.after", 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
